// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multicycle ARM controller.
// The datapath (master) supplies the instruction and ALU flags; the
// controller (slave) returns enables and mux selects.
interface multicycle_ctrl_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    input  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    output RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM controller: main FSM with registered per-state controls,
// instruction/ALU decoder, and conditional-execution logic with stored
// NZCV flags. Write strobes are qualified by the condition result latched
// one cycle earlier.
module multicycle_ctrl (
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_e;

  typedef struct packed {
    logic       next_pc;
    logic       irwrite;
    logic       adrsrc;
    logic       regw;
    logic       memw;
    logic       alu_op;
    logic       branch;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
  } ctrl_t;

  // Control word presented while sitting in a given state.
  function automatic ctrl_t ctrl_for(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.irwrite = 1'b1; c.next_pc = 1'b1; c.alusrca = 2'b01;
                      c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
      DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
      MEMADR:   c.alusrcb = 2'b01;
      MEMRD:    c.adrsrc = 1'b1;
      MEMWB:    begin c.resultsrc = 2'b01; c.regw = 1'b1; end
      MEMWR:    begin c.adrsrc = 1'b1; c.memw = 1'b1; end
      EXECUTER: c.alu_op = 1'b1;
      EXECUTEI: begin c.alusrcb = 2'b01; c.alu_op = 1'b1; end
      ALUWB:    c.regw = 1'b1;
      BRANCH:   begin c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.branch = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign rd    = bus.Instr[15:12];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   n_q, z_q, c_q, v_q;
  logic   condexr_q;
  logic   condex;
  logic [1:0] flagw;
  logic [1:0] alu_ctl;
  logic   pcs;

  // Next-state selection; Instr is sampled live in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE:   case (op)
                  2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
                  2'b01:   state_d = MEMADR;
                  2'b10:   state_d = BRANCH;
                  default: state_d = FETCH;
                endcase
      MEMADR:   state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // State register; the control word is registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_for(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d);
    end
  end

  // ALU operation and flag-write enables; unknown opcodes write no flags.
  always_comb begin
    alu_ctl = 2'b00;
    flagw   = 2'b00;
    if (ctrl_q.alu_op) begin
      case (funct[4:1])
        4'b0100: begin alu_ctl = 2'b00; flagw = {funct[0], funct[0]}; end
        4'b0010: begin alu_ctl = 2'b01; flagw = {funct[0], funct[0]}; end
        4'b0000: begin alu_ctl = 2'b10; flagw = {funct[0], 1'b0}; end
        4'b1100: begin alu_ctl = 2'b11; flagw = {funct[0], 1'b0}; end
        default: begin alu_ctl = 2'b00; flagw = 2'b00; end
      endcase
    end
  end

  // ARM condition-code check against the stored flags.
  always_comb begin
    condex = 1'b0;
    case (cond)
      4'h0: condex = z_q;
      4'h1: condex = ~z_q;
      4'h2: condex = c_q;
      4'h3: condex = ~c_q;
      4'h4: condex = n_q;
      4'h5: condex = ~n_q;
      4'h6: condex = v_q;
      4'h7: condex = ~v_q;
      4'h8: condex = c_q & ~z_q;
      4'h9: condex = ~c_q | z_q;
      4'hA: condex = (n_q == v_q);
      4'hB: condex = (n_q != v_q);
      4'hC: condex = ~z_q & (n_q == v_q);
      4'hD: condex = z_q | (n_q != v_q);
      4'hE: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // Stored flags update only for passing flag-setting ops; CondEx latched each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {n_q, z_q, c_q, v_q} <= 4'b0000;
      condexr_q            <= 1'b0;
    end else begin
      if (flagw[1] & condex) {n_q, z_q} <= bus.ALUFlags[3:2];
      if (flagw[0] & condex) {c_q, v_q} <= bus.ALUFlags[1:0];
      condexr_q <= condex;
    end
  end

  assign pcs = ((rd == 4'hF) & ctrl_q.regw) | ctrl_q.branch;

  assign bus.PCWrite    = ctrl_q.next_pc | (pcs & condexr_q);
  assign bus.RegWrite   = ctrl_q.regw & condexr_q;
  assign bus.MemWrite   = ctrl_q.memw & condexr_q;
  assign bus.IRWrite    = ctrl_q.irwrite;
  assign bus.AdrSrc     = ctrl_q.adrsrc;
  assign bus.ALUSrcA    = ctrl_q.alusrca;
  assign bus.ALUSrcB    = ctrl_q.alusrcb;
  assign bus.ResultSrc  = ctrl_q.resultsrc;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
  assign bus.ImmSrc     = op;
  assign bus.ALUControl = alu_ctl;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed ARM instructions then random ones,
// every cycle's outputs checked against an instruction-level model that
// expands each instruction into its step sequence and tracks NZCV.
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  multicycle_ctrl_if bus();

  multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
                S_EXR, S_EXI, S_ALUWB, S_BRANCH} step_e;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] mflags;     // model {N,Z,C,V}
  bit         cur_pass;   // condition result for the instruction in flight

  // ARM conditions: pairs of codes share a test, odd code inverts it.
  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, cf, v, base;
    {n, z, cf, v} = f;
    base = 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [1:0] alu_sel(logic [31:0] ins);
    case (ins[24:21])
      4'd4:    return 2'b00;  // ADD
      4'd2:    return 2'b01;  // SUB
      4'd0:    return 2'b10;  // AND
      4'd12:   return 2'b11;  // ORR
      default: return 2'b00;
    endcase
  endfunction

  // Expected output vector for one step of an instruction.
  function automatic logic [16:0] exp_out(step_e s, logic [31:0] ins, bit pass);
    logic pcw, memw, regw, irw, adr;
    logic [1:0] srca, srcb, res, aluc, op;
    bit rd15;
    pcw = 0; memw = 0; regw = 0; irw = 0; adr = 0;
    srca = 0; srcb = 0; res = 0; aluc = 0;
    op = ins[27:26];
    rd15 = (ins[15:12] == 4'hF);
    case (s)
      S_FETCH:  begin pcw = 1; irw = 1; srca = 2'b01; srcb = 2'b10; res = 2'b10; end
      S_DECODE: begin srca = 2'b01; srcb = 2'b10; res = 2'b10; end
      S_MEMADR: srcb = 2'b01;
      S_MEMRD:  adr = 1;
      S_MEMWB:  begin res = 2'b01; regw = pass; pcw = pass && rd15; end
      S_MEMWR:  begin adr = 1; memw = pass; end
      S_EXR:    aluc = alu_sel(ins);
      S_EXI:    begin srcb = 2'b01; aluc = alu_sel(ins); end
      S_ALUWB:  begin regw = pass; pcw = pass && rd15; end
      S_BRANCH: begin srcb = 2'b01; res = 2'b10; pcw = pass; end
      default:  ;
    endcase
    return {pcw, memw, regw, irw, adr, op == 2'b01, op == 2'b10,
            srca, srcb, res, op, aluc};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
            bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
            bus.ALUControl};
  endfunction

  task automatic check(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    obs = observed();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  // One clock of one instruction: drive, check mid-cycle, apply flag effects.
  task automatic step(input step_e s, input logic [31:0] ins,
                      input bit ff, input logic [3:0] fv);
    logic [3:0] af;
    @(negedge clk);
    if (s == S_FETCH) begin
      bus.Instr = ins;
      cur_pass  = cond_ok(ins[31:28], mflags);
    end
    af = ff ? fv : 4'($urandom);
    bus.ALUFlags = af;
    #1 check($sformatf("%s@%08h", s.name(), ins), exp_out(s, ins, cur_pass));
    @(posedge clk);
    if ((s == S_EXR || s == S_EXI) && cur_pass && ins[20]) begin
      case (ins[24:21])
        4'd4, 4'd2:  mflags = af;
        4'd0, 4'd12: mflags[3:2] = af[3:2];
        default: ;
      endcase
    end
  endtask

  // Reset pulse: asynchronous effect checked at once and while held over an edge.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1 check({tag, "_async"}, exp_out(S_FETCH, bus.Instr, 1'b0));
    mflags = 4'b0000;
    @(posedge clk);
    #1 check({tag, "_held"}, exp_out(S_FETCH, bus.Instr, 1'b0));
    reset = 1'b0;
  endtask

  // Run one instruction; abort_at >= 0 pulses reset in place of that step.
  task automatic run_instr(input logic [31:0] ins, input int abort_at,
                           input bit ff, input logic [3:0] fv);
    step_e seq[$];
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (ins[27:26])
      2'b00: begin seq.push_back(ins[25] ? S_EXI : S_EXR); seq.push_back(S_ALUWB); end
      2'b01: begin
        seq.push_back(S_MEMADR);
        if (ins[20]) begin seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
        else seq.push_back(S_MEMWR);
      end
      2'b10: seq.push_back(S_BRANCH);
      default: ;
    endcase
    foreach (seq[i]) begin
      if (i == abort_at) begin
        reset_pulse($sformatf("rst@%08h", ins));
        return;
      end
      step(seq[i], ins, ff, fv);
    end
  endtask

  initial begin
    logic [3:0]  cmds [4];
    logic [31:0] ins;
    cmds = '{4'd4, 4'd2, 4'd0, 4'd12};
    reset = 1'b1;
    bus.Instr = 32'h0;
    bus.ALUFlags = 4'h0;
    mflags = 4'b0000;
    cur_pass = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", exp_out(S_FETCH, 32'h0, 1'b0));
    reset = 1'b0;

    run_instr(32'hE0821003, -1, 0, 4'h0);     // ADD R1,R2,R3
    run_instr(32'hE5910004, -1, 0, 4'h0);     // LDR R0,[R1,#4]
    run_instr(32'hE2500001, -1, 1, 4'b0100);  // SUBS -> Z=1
    run_instr(32'h0A000002, -1, 0, 4'h0);     // BEQ taken
    run_instr(32'h1A000002, -1, 0, 4'h0);     // BNE not taken
    run_instr(32'hEC000000, -1, 0, 4'h0);     // Op=11 no-op
    run_instr(32'hE082F003, -1, 0, 4'h0);     // ADD PC,... writes PC
    run_instr(32'hF0821003, -1, 0, 4'h0);     // Cond=1111 never
    run_instr(32'hE0911003, -1, 1, 4'b1111);  // ADDS -> NZCV=1111
    run_instr(32'hE5810000, 3, 0, 4'h0);      // STR, reset in MEMWR
    run_instr(32'h00821003, -1, 0, 4'h0);     // ADDEQ fails (Z cleared)
    run_instr(32'h20821003, -1, 0, 4'h0);     // ADDCS fails
    run_instr(32'h40821003, -1, 0, 4'h0);     // ADDMI fails
    run_instr(32'h60821003, -1, 0, 4'h0);     // ADDVS fails
    run_instr(32'h10821003, -1, 0, 4'h0);     // ADDNE passes

    for (int k = 0; k < 250; k++) begin
      ins = $urandom;
      if (ins[27:26] == 2'b00 && $urandom_range(0, 3) != 0)
        ins[24:21] = cmds[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) ins[15:12] = 4'hF;
      if ($urandom_range(0, 3) == 0) ins[31:28] = 4'hE;
      run_instr(ins, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1,
                0, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
